reg_write_arbiter: RTL

//  Shares the single register-file write port between N_REQ writeback sources
//  (ALU, load unit, debug/loader, ...) using valid/ready handshakes.

---
 rtl/reg_write_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between N_REQ sources.
// Define REG_ARB_PRIO0_EN to give requester 0 fixed top priority over the round-robin.
module reg_write_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [$clog2(N_REQ)-1:0]  last_grant
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   grant_idx;
  logic              grant_vld;
  logic [N_REQ-1:0]  grant;
  logic [IdxW-1:0]   next_ptr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              ptr_upd;

  // Scan from rr_ptr with wrap; ready depends only on req_valid, hold and rr_ptr.
  always_comb begin
    int unsigned pos;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = 0;
    if (rst_n && !hold) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        pos = 32'(rr_ptr_q) + k;
        if (pos >= N_REQ) pos = pos - N_REQ;
        if (!grant_vld && req_valid[pos]) begin
          grant_vld = 1'b1;
          grant_idx = IdxW'(pos);
        end
      end
`ifdef REG_ARB_PRIO0_EN
      if (req_valid[0]) begin
        grant_vld = 1'b1;
        grant_idx = '0;
      end
`endif
      if (grant_vld) grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[grant_idx*DATA_W +: DATA_W];
  assign next_ptr  = (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + IdxW'(1);

`ifdef REG_ARB_PRIO0_EN
  // Priority grants to requester 0 leave the rotation of the others untouched.
  assign ptr_upd = (grant_idx != '0);
`else
  assign ptr_upd = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= '0;
      rr_ptr_q   <= '0;
    end else if (grant_vld) begin
      wr_addr    <= sel_addr;
      wr_data    <= sel_data;
      // Writes to register 0 complete the handshake but are never issued.
      wr_en      <= (sel_addr != '0);
      last_grant <= grant_idx;
      if (ptr_upd) rr_ptr_q <= next_ptr;
    end else begin
      wr_en <= 1'b0;
    end
  end

endmodule
